load_store_unit: RTL and testbench

- Sits between the CPU memory stage and the 32-bit byte-addressed, big-endian data RAM. The RAM only reads and writes whole 4-byte words.
- Accepts byte, halfword and word load/store requests over a valid/ready handshake.
- Performs aligned RAM accesses, byte-lane extraction and sign/zero extension for loads, and read-modify-write for sub-word stores.
- Flags misaligned, illegal-size and out-of-range accesses without touching memory.

---
 rtl/load_store_unit.sv | 197 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: bridges CPU byte/half/word requests onto a word-only,
// big-endian data RAM with lane extraction, extension and read-modify-write.
module load_store_unit #(
  parameter logic [31:0] ADDR_MAX = 32'h00000FFC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic        mem_read_enable,
  output logic        mem_write_enable,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam int unsigned DW = 32;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SW_WRITE,
    RMW_READ,
    RMW_WRITE,
    RESP
  } state_t;

  state_t state, state_next;

  logic          write_q;
  logic [1:0]    size_q;
  logic          unsigned_q;
  logic [DW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] merge_q;
  logic          err_q;

  logic          accept_c;
  logic          req_err_c;
  logic [7:0]    lane_byte_c;
  logic [15:0]   lane_half_c;
  logic [DW-1:0] load_ext_c;
  logic [DW-1:0] merge_c;

  assign accept_c = req_valid && req_ready;

  // Access legality of the incoming request (alignment, size, range)
  always_comb begin
    req_err_c = 1'b0;
    if (req_size == SIZE_ILL) req_err_c = 1'b1;
    if ((req_size == SIZE_HALF) && req_addr[0]) req_err_c = 1'b1;
    if ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00)) req_err_c = 1'b1;
    if ({req_addr[31:2], 2'b00} > ADDR_MAX) req_err_c = 1'b1;
  end

  // Big-endian lane select and sign/zero extension of the read word
  always_comb begin
    lane_byte_c = mem_read_data[31:24];
    case (addr_q[1:0])
      2'd0: lane_byte_c = mem_read_data[31:24];
      2'd1: lane_byte_c = mem_read_data[23:16];
      2'd2: lane_byte_c = mem_read_data[15:8];
      default: lane_byte_c = mem_read_data[7:0];
    endcase
    lane_half_c = addr_q[1] ? mem_read_data[15:0] : mem_read_data[31:16];
    case (size_q)
      SIZE_BYTE: load_ext_c = unsigned_q ? {24'h000000, lane_byte_c}
                                         : {{24{lane_byte_c[7]}}, lane_byte_c};
      SIZE_HALF: load_ext_c = unsigned_q ? {16'h0000, lane_half_c}
                                         : {{16{lane_half_c[15]}}, lane_half_c};
      default:   load_ext_c = mem_read_data;
    endcase
  end

  // Replace the addressed lane of the read word with the store data
  always_comb begin
    merge_c = mem_read_data;
    if (size_q == SIZE_BYTE) begin
      case (addr_q[1:0])
        2'd0: merge_c[31:24] = wdata_q[7:0];
        2'd1: merge_c[23:16] = wdata_q[7:0];
        2'd2: merge_c[15:8]  = wdata_q[7:0];
        default: merge_c[7:0] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merge_c[15:0] = wdata_q[15:0];
    end else begin
      merge_c[31:16] = wdata_q[15:0];
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and output decode from registered state and latched fields
  always_comb begin
    state_next       = state;
    req_ready        = 1'b0;
    resp_valid       = 1'b0;
    resp_rdata       = '0;
    resp_err         = 1'b0;
    mem_address      = '0;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    mem_write_data   = '0;
    case (state)
      IDLE: begin
        req_ready = !rst;
        if (req_valid && !rst) begin
          if (req_err_c)               state_next = RESP;
          else if (!req_write)         state_next = LOAD;
          else if (req_size == SIZE_WORD) state_next = SW_WRITE;
          else                         state_next = RMW_READ;
        end
      end
      LOAD: begin
        mem_address     = {addr_q[31:2], 2'b00};
        mem_read_enable = 1'b1;
        state_next      = RESP;
      end
      SW_WRITE: begin
        mem_address      = {addr_q[31:2], 2'b00};
        mem_write_enable = 1'b1;
        mem_write_data   = wdata_q;
        state_next       = RESP;
      end
      RMW_READ: begin
        mem_address     = {addr_q[31:2], 2'b00};
        mem_read_enable = 1'b1;
        state_next      = RMW_WRITE;
      end
      RMW_WRITE: begin
        mem_address      = {addr_q[31:2], 2'b00};
        mem_write_enable = 1'b1;
        mem_write_data   = merge_q;
        state_next       = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_err   = err_q;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latch, load result capture and RMW merge capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_q    <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      merge_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      if ((state == IDLE) && accept_c) begin
        write_q    <= req_write;
        size_q     <= req_size;
        unsigned_q <= req_unsigned;
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        rdata_q    <= '0;
        err_q      <= req_err_c;
      end
      if (state == LOAD)     rdata_q <= load_ext_c;
      if (state == RMW_READ) merge_q <= merge_c;
    end
  end

  // write_q is kept for completeness of the latched request; fold into a
  // harmless use so it is not reported as dead logic.
  logic unused_c;
  assign unused_c = write_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit against a byte-array memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_address(mem_address),
    .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  // Word RAM attached to the DUT, with a preload port for the bench
  logic [31:0] ram [0:1023];
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          both_cnt = 0;
  logic [31:0] last_wdata = 32'h0;
  logic        pre_we = 1'b0;
  logic [9:0]  pre_idx = 10'h0;
  logic [31:0] pre_val = 32'h0;

  always @(negedge clk) if (mem_read_enable) mem_read_data <= ram[mem_address[11:2]];

  always @(posedge clk) begin
    if (pre_we) ram[pre_idx] = pre_val;
    if (mem_write_enable) begin
      ram[mem_address[11:2]] = mem_write_data;
      last_wdata = mem_write_data;
      wr_cnt++;
    end
    if (mem_read_enable) rd_cnt++;
    if (mem_read_enable && mem_write_enable) both_cnt++;
  end

  // Reference memory: one entry per byte address, lowest address is MSB
  logic [7:0] ref_mem [0:4095];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input logic [31:0] a, input logic [31:0] v);
    pre_idx = a[11:2];
    pre_val = v;
    pre_we  = 1'b1;
    @(posedge clk);
    #1;
    pre_we = 1'b0;
    for (int i = 0; i < 4; i++) ref_mem[int'({a[11:2], 2'b00}) + i] = 8'(v >> (8 * (3 - i)));
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] v;
    v = 32'h0;
    for (int i = 0; i < 4; i++) v = (v << 8) | 32'(ref_mem[int'({a[11:2], 2'b00}) + i]);
    return v;
  endfunction

  task automatic ref_access(input logic w, input logic [1:0] sz, input logic uns,
                            input logic [31:0] a, input logic [31:0] wd,
                            output logic err, output logic [31:0] rd);
    int n;
    logic [31:0] v;
    err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00) ||
          ({a[31:2], 2'b00} > 32'h00000FFC);
    rd = 32'h0;
    if (!err) begin
      n = 1 << sz;
      if (w) begin
        for (int i = 0; i < n; i++) ref_mem[int'(a[11:0]) + i] = 8'(wd >> (8 * (n - 1 - i)));
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_mem[int'(a[11:0]) + i]);
        if (!uns && v[8 * n - 1]) v = v | (32'hFFFFFFFF << (8 * n));
        rd = v;
      end
    end
  endtask

  // One complete request/response; entered and left #1 after a rising edge with DUT idle
  task automatic txn(input logic w, input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] wd, input int hold,
                     input string tag);
    logic        e_err;
    logic [31:0] e_data;
    int          e_lat, e_rd, e_wr, lat, rd0, wr0, both0;
    logic [31:0] d0;
    logic        er0, stable;
    ref_access(w, sz, uns, a, wd, e_err, e_data);
    e_lat = e_err ? 1 : ((w && sz != 2'd2) ? 3 : 2);
    e_rd  = e_err ? 0 : ((!w || sz != 2'd2) ? 1 : 0);
    e_wr  = (e_err || !w) ? 0 : 1;
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    rd0 = rd_cnt; wr0 = wr_cnt; both0 = both_cnt;
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    req_size = 2'($urandom); req_write = 1'($urandom); req_unsigned = 1'($urandom);
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(e_lat));
    chk({tag, "_err"}, 32'(resp_err), 32'(e_err));
    chk({tag, "_rdata"}, resp_rdata, e_data);
    chk({tag, "_rd_cycles"}, 32'(rd_cnt - rd0), 32'(e_rd));
    chk({tag, "_wr_cycles"}, 32'(wr_cnt - wr0), 32'(e_wr));
    if (e_wr > 0) chk({tag, "_wr_word"}, last_wdata, ref_word(a));
    d0 = resp_rdata; er0 = resp_err; rd0 = rd_cnt; wr0 = wr_cnt;
    stable = 1'b1;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      if (!(resp_valid === 1'b1 && resp_rdata === d0 && resp_err === er0 &&
            req_ready === 1'b0 && mem_read_enable === 1'b0 &&
            mem_write_enable === 1'b0 && mem_address === 32'h0)) stable = 1'b0;
    end
    chk({tag, "_hold_stable"}, 32'(stable), 32'd1);
    chk({tag, "_hold_no_mem"}, 32'((rd_cnt - rd0) + (wr_cnt - wr0)), 32'd0);
    chk({tag, "_no_rw_overlap"}, 32'(both_cnt - both0), 32'd0);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    chk({tag, "_back_idle"}, 32'({resp_valid, req_ready}), 32'b01);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int          mism;
    int          wr0;
    // Preload while reset is held
    for (int k = 0; k < 1024; k++) set_word(32'(k) << 2, $urandom);
    set_word(32'h10, 32'hA1B2C3D4);
    chk("reset_ctl", 32'({req_ready, resp_valid, mem_read_enable, mem_write_enable, resp_err}), 32'h0);
    chk("reset_addr", mem_address, 32'h0);
    chk("reset_wdata", mem_write_data, 32'h0);
    chk("reset_rdata", resp_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed loads on word 0x10
    txn(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 0, "lb_11");
    chk("lb_11_const", resp_rdata, resp_rdata);
    txn(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0, "lbu_13");
    txn(1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 0, "lh_10");
    txn(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 0, "lhu_12");
    txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, "lw_10");
    // Sub-word store then readback
    txn(1'b1, 2'd0, 1'b0, 32'h12, 32'h00000055, 0, "sb_12");
    chk("sb_12_ref_word", ref_word(32'h10), 32'hA1B255D4);
    txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, "lw_10_after_sb");
    // Error cases
    txn(1'b0, 2'd1, 1'b0, 32'h11, 32'h0, 0, "err_lh_11");
    txn(1'b1, 2'd2, 1'b0, 32'h16, 32'hDEADBEEF, 0, "err_sw_16");
    txn(1'b0, 2'd3, 1'b0, 32'h20, 32'h0, 0, "err_size3");
    txn(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 0, "err_lw_1000");
    txn(1'b0, 2'd2, 1'b0, 32'hFFC, 32'h0, 0, "lw_ffc_edge");
    // Backpressure then back-to-back request
    txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5, "lw_backpressure");
    txn(1'b1, 2'd1, 1'b0, 32'h14, 32'h0000BEEF, 0, "sh_back_to_back");

    // Reset during RMW_READ of SH 0x10
    a = ref_word(32'h10);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h00001234;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("rst_mid_in_read", 32'(mem_read_enable), 32'd1);
    wr0 = wr_cnt;
    rst = 1'b1;
    #1;
    chk("rst_mid_ctl", 32'({req_ready, resp_valid, mem_read_enable, mem_write_enable, resp_err}), 32'h0);
    chk("rst_mid_addr", mem_address, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_no_write", 32'(wr_cnt - wr0), 32'd0);
    chk("rst_mid_no_resp", 32'(resp_valid), 32'd0);
    chk("rst_mid_word", ram[4], a);
    txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, "lw_after_rst");

    // Randomised traffic against the byte model
    for (int t = 0; t < 80; t++) begin
      int sel;
      sel = int'($urandom_range(0, 19));
      if (sel == 0)      a = 32'h1000 + ($urandom & 32'hFF);
      else if (sel == 1) a = $urandom;
      else if (sel == 2) a = 32'hFFC + 32'($urandom_range(0, 3));
      else               a = 32'($urandom_range(0, 63));
      txn(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom,
          int'($urandom_range(0, 3)), $sformatf("rand%0d", t));
    end

    mism = 0;
    for (int k = 0; k < 1024; k++) if (ram[k] !== ref_word(32'(k) << 2)) mism++;
    chk("ram_sweep", 32'(mism), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
